// File: rtl/cc_bbox_collector.sv
// Per-label bounding-box and pixel-count collector for a connected-component label stream.
// Accumulates over a frame, then drains one record per live label over valid/ready and re-arms.
module cc_bbox_collector #(
    parameter int LABEL_WIDTH = 8,
    parameter int NUM_LABELS  = 32,
    parameter int COORD_WIDTH = 10,
    parameter int COUNT_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic                   vsync,
    input  logic [31:0]            x,
    input  logic [31:0]            y,
    input  logic [LABEL_WIDTH-1:0] label,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LABEL_WIDTH-1:0] out_label,
    output logic [COORD_WIDTH-1:0] out_xmin,
    output logic [COORD_WIDTH-1:0] out_xmax,
    output logic [COORD_WIDTH-1:0] out_ymin,
    output logic [COORD_WIDTH-1:0] out_ymax,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   frame_done,
    output logic                   overflow,
    output logic                   busy
);
    localparam int IDX_W = $clog2(NUM_LABELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LABELS - 1);

    typedef enum logic {ACCUM = 1'b0, FLUSH = 1'b1} state_t;

    state_t                 state_r;
    logic [IDX_W-1:0]       idx_r;
    logic                   vsync_prev_r;
    logic [NUM_LABELS-1:0]  valid_r;
    logic [COORD_WIDTH-1:0] xmin_r  [NUM_LABELS];
    logic [COORD_WIDTH-1:0] xmax_r  [NUM_LABELS];
    logic [COORD_WIDTH-1:0] ymin_r  [NUM_LABELS];
    logic [COORD_WIDTH-1:0] ymax_r  [NUM_LABELS];
    logic [COUNT_WIDTH-1:0] count_r [NUM_LABELS];

    logic [IDX_W-1:0]       lidx_s;
    logic [IDX_W-1:0]       nidx_s;
    logic [IDX_W-1:0]       sel_s;
    logic [COORD_WIDTH-1:0] px_s;
    logic [COORD_WIDTH-1:0] py_s;
    logic                   in_table_s;
    logic                   pix_s;
    logic                   ovf_s;
    logic                   edge_s;
    logic                   accept_s;
    logic                   unused_s;

    assign lidx_s     = label[IDX_W-1:0];
    assign nidx_s     = idx_r + IDX_W'(1);
    assign px_s       = x[COORD_WIDTH-1:0];
    assign py_s       = y[COORD_WIDTH-1:0];
    assign in_table_s = label < LABEL_WIDTH'(NUM_LABELS);
    assign pix_s      = (state_r == ACCUM) && en && (label != '0) && in_table_s;
    assign ovf_s      = (state_r == ACCUM) && en && !in_table_s;
    assign edge_s     = vsync & ~vsync_prev_r;
    assign accept_s   = out_valid & out_ready;
    // While a record is presented, the only load that can happen is the look-ahead on acceptance.
    assign sel_s      = out_valid ? nidx_s : idx_r;
    assign unused_s   = &{1'b0, x[31:COORD_WIDTH], y[31:COORD_WIDTH]};

    // Collector state machine: table accumulation in ACCUM, record drain in FLUSH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ACCUM;
            idx_r        <= IDX_W'(1);
            vsync_prev_r <= 1'b0;
            valid_r      <= '0;
            out_valid    <= 1'b0;
            out_label    <= '0;
            out_xmin     <= '0;
            out_xmax     <= '0;
            out_ymin     <= '0;
            out_ymax     <= '0;
            out_count    <= '0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
            for (int i = 0; i < NUM_LABELS; i++) begin
                xmin_r[i]  <= '0;
                xmax_r[i]  <= '0;
                ymin_r[i]  <= '0;
                ymax_r[i]  <= '0;
                count_r[i] <= '0;
            end
        end else begin
            vsync_prev_r <= vsync;
            frame_done   <= 1'b0;
            case (state_r)
                ACCUM: begin
                    if (pix_s) begin
                        if (!valid_r[lidx_s]) begin
                            valid_r[lidx_s] <= 1'b1;
                            xmin_r[lidx_s]  <= px_s;
                            xmax_r[lidx_s]  <= px_s;
                            ymin_r[lidx_s]  <= py_s;
                            ymax_r[lidx_s]  <= py_s;
                            count_r[lidx_s] <= COUNT_WIDTH'(1);
                        end else begin
                            if (px_s < xmin_r[lidx_s]) xmin_r[lidx_s] <= px_s;
                            if (px_s > xmax_r[lidx_s]) xmax_r[lidx_s] <= px_s;
                            if (py_s < ymin_r[lidx_s]) ymin_r[lidx_s] <= py_s;
                            if (py_s > ymax_r[lidx_s]) ymax_r[lidx_s] <= py_s;
                            if (count_r[lidx_s] != '1) count_r[lidx_s] <= count_r[lidx_s] + COUNT_WIDTH'(1);
                        end
                    end
                    if (ovf_s) overflow <= 1'b1;
                    if (edge_s) begin
                        state_r <= FLUSH;
                        busy    <= 1'b1;
                        idx_r   <= IDX_W'(1);
                    end
                end
                FLUSH: begin
                    if (accept_s) valid_r[idx_r] <= 1'b0;
                    if (out_valid && !out_ready) begin
                        out_valid <= 1'b1;
                    end else if (!out_valid && valid_r[idx_r]) begin
                        out_valid <= 1'b1;
                        out_label <= LABEL_WIDTH'(sel_s);
                        out_xmin  <= xmin_r[sel_s];
                        out_xmax  <= xmax_r[sel_s];
                        out_ymin  <= ymin_r[sel_s];
                        out_ymax  <= ymax_r[sel_s];
                        out_count <= count_r[sel_s];
                    end else if (idx_r == LAST_IDX) begin
                        out_valid  <= 1'b0;
                        frame_done <= 1'b1;
                        overflow   <= 1'b0;
                        busy       <= 1'b0;
                        state_r    <= ACCUM;
                        idx_r      <= IDX_W'(1);
                    end else begin
                        idx_r <= nidx_s;
                        // Look ahead so a continuously-ready consumer gets one record per cycle.
                        if (accept_s && valid_r[nidx_s]) begin
                            out_valid <= 1'b1;
                            out_label <= LABEL_WIDTH'(sel_s);
                            out_xmin  <= xmin_r[sel_s];
                            out_xmax  <= xmax_r[sel_s];
                            out_ymin  <= ymin_r[sel_s];
                            out_ymax  <= ymax_r[sel_s];
                            out_count <= count_r[sel_s];
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r   <= ACCUM;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cc_bbox_collector.sv
// Randomized self-checking bench for cc_bbox_collector against a per-label array model.
// COUNT_WIDTH is reduced to 12 so saturation is reachable in a short run.
module tb_cc_bbox_collector;
    localparam int LW  = 8;
    localparam int NL  = 32;
    localparam int CWD = 10;
    localparam int CNW = 12;
    localparam int unsigned CMAX = (1 << CNW) - 1;
    localparam int unsigned CMASK = (1 << CWD) - 1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            en = 1'b0;
    logic            vsync = 1'b0;
    logic [31:0]     x = 32'd0;
    logic [31:0]     y = 32'd0;
    logic [LW-1:0]   label = '0;
    logic            out_ready = 1'b0;
    logic            out_valid;
    logic [LW-1:0]   out_label;
    logic [CWD-1:0]  out_xmin, out_xmax, out_ymin, out_ymax;
    logic [CNW-1:0]  out_count;
    logic            frame_done, overflow, busy;

    cc_bbox_collector #(.LABEL_WIDTH(LW), .NUM_LABELS(NL), .COORD_WIDTH(CWD), .COUNT_WIDTH(CNW)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .vsync(vsync), .x(x), .y(y), .label(label),
        .out_valid(out_valid), .out_ready(out_ready), .out_label(out_label),
        .out_xmin(out_xmin), .out_xmax(out_xmax), .out_ymin(out_ymin), .out_ymax(out_ymax),
        .out_count(out_count), .frame_done(frame_done), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    bit          m_v  [NL];
    int unsigned m_x0 [NL];
    int unsigned m_x1 [NL];
    int unsigned m_y0 [NL];
    int unsigned m_y1 [NL];
    int unsigned m_c  [NL];
    bit          m_ovf;

    function automatic void model_clear();
        for (int i = 0; i < NL; i++) m_v[i] = 1'b0;
        m_ovf = 1'b0;
    endfunction

    function automatic void model_pixel(input int lab, input int unsigned xx, input int unsigned yy);
        int unsigned cx, cy;
        cx = xx & CMASK;
        cy = yy & CMASK;
        if (lab >= NL) m_ovf = 1'b1;
        else if (lab != 0) begin
            if (!m_v[lab]) begin
                m_v[lab] = 1'b1;
                m_x0[lab] = cx; m_x1[lab] = cx; m_y0[lab] = cy; m_y1[lab] = cy; m_c[lab] = 1;
            end else begin
                if (cx < m_x0[lab]) m_x0[lab] = cx;
                if (cx > m_x1[lab]) m_x1[lab] = cx;
                if (cy < m_y0[lab]) m_y0[lab] = cy;
                if (cy > m_y1[lab]) m_y1[lab] = cy;
                if (m_c[lab] < CMAX) m_c[lab] = m_c[lab] + 1;
            end
        end
    endfunction

    // One accumulate-phase pixel; vs=1 makes this the frame-end edge cycle.
    task automatic px(input bit e, input int lab, input int unsigned xx, input int unsigned yy, input bit vs);
        en = e; label = lab[LW-1:0]; x = xx; y = yy; vsync = vs;
        if (e) model_pixel(lab, xx, yy);
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    // Drain after the edge cycle; junk pixels and vsync toggles are driven throughout.
    task automatic collect(input bit rand_ready, input int stall_first, input int exp_cycles);
        int q[$];
        int cycles, vseen, lab;
        bit rdy, stalled, done;
        logic [63:0] held;
        chk("busy_on", busy, 1'b1);
        chk("ovf_flush", overflow, m_ovf);
        for (int i = 1; i < NL; i++) if (m_v[i]) q.push_back(i);
        cycles = 0; vseen = 0; stalled = 1'b0; done = 1'b0; held = '0;
        while (!done) begin
            if (frame_done) begin
                done = 1'b1;
            end else begin
                if (stalled) begin
                    chk("stall_valid", out_valid, 1'b1);
                    chk("stall_hold", {out_label, out_xmin, out_xmax, out_ymin, out_ymax, out_count} == held[LW+4*CWD+CNW-1:0], 1'b1);
                end
                rdy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (vseen < stall_first) rdy = 1'b0;
                if (out_valid) vseen++;
                out_ready = rdy;
                en = $urandom_range(0, 1); label = LW'($urandom_range(0, 45));
                x = $urandom; y = $urandom; vsync = $urandom_range(0, 1);
                if (out_valid && rdy) begin
                    if (q.size() == 0) chk("extra_record", out_label, 0);
                    else begin
                        lab = q.pop_front();
                        chk("rec_label", out_label, lab);
                        chk("rec_xmin", out_xmin, m_x0[lab]);
                        chk("rec_xmax", out_xmax, m_x1[lab]);
                        chk("rec_ymin", out_ymin, m_y0[lab]);
                        chk("rec_ymax", out_ymax, m_y1[lab]);
                        chk("rec_count", out_count, m_c[lab]);
                    end
                end
                stalled = out_valid && !rdy;
                held = {out_label, out_xmin, out_xmax, out_ymin, out_ymax, out_count};
                @(posedge clk); #1;
                cycles++;
                if (cycles > 3000) begin
                    chk("drain_timeout", 1'b1, 1'b0);
                    done = 1'b1;
                end
            end
        end
        chk("records_left", q.size(), 0);
        chk("ovf_cleared", overflow, 1'b0);
        chk("busy_off", busy, 1'b0);
        if (exp_cycles >= 0) chk("empty_scan_cycles", cycles, exp_cycles);
        en = 1'b0; vsync = 1'b0; out_ready = 1'b0;
        model_clear();
        @(posedge clk); #1;
        chk("frame_done_pulse", frame_done, 1'b0);
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", {out_label, out_xmin, out_count} == '0, 1'b1);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // single label, edge cycle carries the last pixel
        px(1'b1, 5, 10, 4, 1'b0);
        px(1'b1, 5, 12, 2, 1'b0);
        px(1'b1, 5, 11, 7, 1'b1);
        collect(1'b0, 0, -1);

        // two labels, consumer stalls the first record
        px(1'b1, 9, 300, 40, 1'b0);
        px(1'b1, 3, 7, 8, 1'b0);
        px(1'b1, 9, 290, 44, 1'b0);
        px(1'b1, 3, 5, 9, 1'b0);
        px(1'b0, 0, 0, 0, 1'b1);
        collect(1'b0, 5, -1);

        // out-of-table label only
        px(1'b1, 40, 1, 1, 1'b0);
        px(1'b1, 0, 2, 2, 1'b1);
        collect(1'b0, 0, 30 + 1);

        // disabled and background pixels only: empty scan
        px(1'b0, 7, 3, 3, 1'b0);
        px(1'b1, 0, 4, 4, 1'b0);
        px(1'b0, 7, 5, 5, 1'b1);
        collect(1'b0, 0, NL - 1);

        // count saturation with wide coordinates
        for (int i = 0; i < int'(CMAX) + 4; i++) px(1'b1, 2, 32'h0001_0000 + (i % 700), 900 - (i % 50), 1'b0);
        px(1'b0, 0, 0, 0, 1'b1);
        collect(1'b1, 0, -1);

        // reset mid-drain with a record presented
        px(1'b1, 4, 20, 20, 1'b0);
        px(1'b1, 6, 30, 30, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            en = 1'b1; label = 8'd4; x = 32'd1; y = 32'd1;
            @(posedge clk); #1;
        end
        chk("t6_valid", out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_done", frame_done, 1'b0);
        en = 1'b0;
        model_clear();
        @(posedge clk); #1;
        reset_n = 1'b1;
        px(1'b1, 6, 100, 200, 1'b0);
        px(1'b1, 6, 5, 5, 1'b1);
        collect(1'b1, 0, -1);

        // random frames
        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(20, 60);
            for (int p = 0; p < n; p++)
                px(($urandom_range(0, 3) != 0), $urandom_range(0, 40), $urandom, $urandom, 1'b0);
            px(($urandom_range(0, 1) == 1), $urandom_range(0, 40), $urandom, $urandom, 1'b1);
            collect(1'b1, 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
